// File: rtl/mips_instr_encoder.sv
// Field-level MIPS instruction encoder that streams assembled words into
// instruction memory at consecutive word addresses (program preload path).
module mips_instr_encoder #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic              busy,
  output logic              done,
  output logic              err_illegal_op,
  output logic              addr_wrap,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_MAX   = {(ADDR_W+1){1'b1}};

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= 4'd8);
  endfunction

  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    case (op)
      4'd0:    word = {6'b000000, rs, rt, rd, 5'b00000, funct};
      4'd1:    word = {6'b100011, rs, rt, imm};
      4'd2:    word = {6'b101011, rs, rt, imm};
      4'd3:    word = {6'b000100, rs, rt, imm};
      4'd4:    word = {6'b000101, rs, rt, imm};
      4'd5:    word = {6'b001000, rs, rt, imm};
      4'd6:    word = {6'b000010, target};
      4'd7:    word = {6'b000011, target};
      4'd8:    word = {6'b000000, rs, 15'b0, 6'b001000};
      default: word = 32'd0;
    endcase
    return word;
  endfunction

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_last;
  logic              r_err;
  logic              r_wrap;
  logic [ADDR_W:0]   r_count;

  // Session FSM: accept fields, hold the encoded word until acked, then advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= BASE_ADDR;
      r_wdata <= 32'd0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_wrap  <= 1'b0;
      r_count <= CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_err   <= 1'b0;
            r_wrap  <= 1'b0;
            r_count <= CNT_ZERO;
            r_addr  <= BASE_ADDR;
            r_state <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (in_valid) begin
            if (op_is_legal(in_op)) begin
              r_wdata <= encode(in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target);
              r_last  <= in_last;
              r_state <= ST_WRITE;
            end else begin
              // Illegal op is dropped without consuming an address slot.
              r_err   <= 1'b1;
              r_state <= in_last ? ST_DONE : ST_ACCEPT;
            end
          end
        end
        ST_WRITE: begin
          if (imem_ack) begin
            r_addr <= r_addr + ADDR_ONE;
            if (&r_addr) begin
              r_wrap <= 1'b1;
            end
            if (r_count != CNT_MAX) begin
              r_count <= r_count + CNT_ONE;
            end
            r_state <= r_last ? ST_DONE : ST_ACCEPT;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready       = (r_state == ST_ACCEPT);
  assign imem_we        = (r_state == ST_WRITE);
  // Address bus is only meaningful during a write; keep it at zero otherwise.
  assign imem_addr      = imem_we ? r_addr : ADDR_ZERO;
  assign imem_wdata     = r_wdata;
  assign busy           = (r_state != ST_IDLE);
  assign done           = (r_state == ST_DONE);
  assign err_illegal_op = r_err;
  assign addr_wrap      = r_wrap;
  assign word_count     = r_count;

endmodule
